// File: rtl/byte_ram_ctrl_if.sv
// byte_ram_ctrl_if: per-byte CPU <-> RAM handshake bundle.
interface byte_ram_ctrl_if;
    logic [1:0]  mem_ctrl;
    logic [15:0] data_addr;
    logic [7:0]  data_store;
    logic        cpu_ready;
    logic        cpu_send;
    logic        cpu_receive;
    logic [7:0]  data_read;
    logic        ram_send;
    logic        ram_receive;
    modport master (
        output mem_ctrl, data_addr, data_store, cpu_ready, cpu_send, cpu_receive,
        input  data_read, ram_send, ram_receive
    );
    modport slave (
        input  mem_ctrl, data_addr, data_store, cpu_ready, cpu_send, cpu_receive,
        output data_read, ram_send, ram_receive
    );
endinterface

// File: rtl/byte_ram_ctrl.sv
// byte_ram_ctrl: byte-wide RAM slave with read latency, preload port and sticky error flag.
module byte_ram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    byte_ram_ctrl_if.slave    bus,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_SEND, WR_ACK} state_t;
    state_t            state;
    logic [ADDR_W-1:0] a;
    logic              oor_q;
    logic [3:0]        cnt;
    logic [7:0]        mem [2**ADDR_W];
    logic              oor;
    logic              wr_hit;
    assign oor    = (bus.data_addr >> ADDR_W) != 16'd0;
    assign wr_hit = state == IDLE && bus.mem_ctrl == 2'b01 && bus.cpu_send;
    // Preload owns the write port; a colliding CPU write is acked but lost.
    always_ff @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (wr_hit && !oor)
            mem[bus.data_addr[ADDR_W-1:0]] <= bus.data_store;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            a               <= '0;
            oor_q           <= 1'b0;
            cnt             <= 4'd0;
            bus.data_read   <= 8'h00;
            bus.ram_send    <= 1'b0;
            bus.ram_receive <= 1'b0;
            busy            <= 1'b0;
            err             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_ctrl == 2'b10 && bus.cpu_ready) begin
                        a     <= bus.data_addr[ADDR_W-1:0];
                        oor_q <= oor;
                        cnt   <= 4'(RD_LAT);
                        err   <= err | oor;
                        busy  <= 1'b1;
                        state <= RD_WAIT;
                    end else if (wr_hit) begin
                        bus.ram_receive <= 1'b1;
                        err             <= err | oor;
                        busy            <= 1'b1;
                        state           <= WR_ACK;
                    end else if (bus.mem_ctrl == 2'b11)
                        err <= 1'b1;
                end
                RD_WAIT: begin
                    if (bus.mem_ctrl != 2'b10) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else begin
                        bus.data_read <= oor_q ? 8'h00 : mem[a];
                        bus.ram_send  <= 1'b1;
                        state         <= RD_SEND;
                    end
                end
                RD_SEND: begin
                    if (bus.cpu_receive || bus.mem_ctrl != 2'b10) begin
                        bus.ram_send <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WR_ACK: begin
                    // Re-arm only once cpu_send is seen low, so a held level writes once.
                    if (!bus.cpu_send) begin
                        bus.ram_receive <= 1'b0;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_ram_ctrl.sv
// tb_byte_ram_ctrl: directed vector table plus hand sequences for byte_ram_ctrl.
module tb_byte_ram_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;
    logic       busy1, err1, busy3, err3;
    int         n_cmp = 0;
    int         n_bad = 0;
    byte_ram_ctrl_if b1();
    byte_ram_ctrl_if b3();
    byte_ram_ctrl #(.ADDR_W(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(busy1), .err(err1)
    );
    byte_ram_ctrl #(.ADDR_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(busy3), .err(err3)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } vec_t;
    vec_t tbl [17];
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    task automatic preload(input logic [7:0] addr, input logic [7:0] data);
        ld_en = 1'b1;
        ld_addr = addr;
        ld_data = data;
        tick;
        ld_en = 1'b0;
    endtask
    task automatic rd(input logic [15:0] addr, input logic [7:0] exp);
        int n;
        b1.mem_ctrl = 2'b10;
        b1.data_addr = addr;
        b1.cpu_ready = 1'b1;
        tick;
        b1.cpu_ready = 1'b0;
        n = 0;
        while (!b1.ram_send && n < 20) begin
            tick;
            n++;
        end
        check("rd_latency", 16'(n), 16'd2);
        check("rd_data", {8'h00, b1.data_read}, {8'h00, exp});
        tick;
        check("rd_hold", {7'd0, b1.ram_send, b1.data_read}, {8'h01, exp});
        b1.cpu_receive = 1'b1;
        tick;
        check("rd_release", {14'd0, b1.ram_send, busy1}, 16'd0);
        b1.cpu_receive = 1'b0;
        b1.mem_ctrl = 2'b00;
    endtask
    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        b1.mem_ctrl = 2'b01;
        b1.data_addr = addr;
        b1.data_store = data;
        b1.cpu_send = 1'b1;
        tick;
        check("wr_ack", {14'd0, b1.ram_receive, busy1}, 16'd3);
        b1.cpu_send = 1'b0;
        tick;
        check("wr_release", {14'd0, b1.ram_receive, busy1}, 16'd0);
        b1.mem_ctrl = 2'b00;
    endtask
    initial begin
        int  n;
        bit  seen;
        b1.mem_ctrl = 2'b00; b1.data_addr = 16'h0; b1.data_store = 8'h0;
        b1.cpu_ready = 1'b0; b1.cpu_send = 1'b0; b1.cpu_receive = 1'b0;
        b3.mem_ctrl = 2'b00; b3.data_addr = 16'h0; b3.data_store = 8'h0;
        b3.cpu_ready = 1'b0; b3.cpu_send = 1'b0; b3.cpu_receive = 1'b0;
        tbl = '{
            '{1'b0, 16'h0010, 8'hA5}, '{1'b1, 16'h0020, 8'h3C}, '{1'b0, 16'h0020, 8'h3C},
            '{1'b1, 16'h0030, 8'h55}, '{1'b1, 16'h0031, 8'h55}, '{1'b0, 16'h0030, 8'h55},
            '{1'b0, 16'h0031, 8'h55}, '{1'b0, 16'h0032, 8'hEE}, '{1'b0, 16'h00FF, 8'h5A},
            '{1'b1, 16'h00FF, 8'hC3}, '{1'b0, 16'h00FF, 8'hC3}, '{1'b0, 16'h0000, 8'h12},
            '{1'b0, 16'h0001, 8'h34}, '{1'b1, 16'h0004, 8'h12}, '{1'b1, 16'h0005, 8'h34},
            '{1'b0, 16'h0004, 8'h12}, '{1'b0, 16'h0005, 8'h34}
        };
        tick;
        tick;
        rst = 1'b0;
        check("reset_dut1", {3'd0, b1.data_read, b1.ram_send, b1.ram_receive, busy1, err1}, 16'd0);
        check("reset_dut3", {3'd0, b3.data_read, b3.ram_send, b3.ram_receive, busy3, err3}, 16'd0);
        preload(8'h10, 8'hA5);
        preload(8'h00, 8'h12);
        preload(8'h01, 8'h34);
        preload(8'h32, 8'hEE);
        preload(8'h41, 8'h99);
        preload(8'h51, 8'h11);
        preload(8'hFF, 8'h5A);
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
            else rd(tbl[i].addr, tbl[i].data);
        end
        // cpu_send held high while the address moves must write exactly once
        b1.mem_ctrl = 2'b01; b1.data_addr = 16'h0050; b1.data_store = 8'h66; b1.cpu_send = 1'b1;
        tick;
        b1.data_addr = 16'h0051;
        tick;
        tick;
        check("hold_ack", {15'd0, b1.ram_receive}, 16'd1);
        b1.cpu_send = 1'b0;
        tick;
        b1.mem_ctrl = 2'b00;
        rd(16'h0051, 8'h11);
        rd(16'h0050, 8'h66);
        // preload collides with a CPU write: preload lands, CPU byte dropped but acked
        b1.mem_ctrl = 2'b01; b1.data_addr = 16'h0041; b1.data_store = 8'h77; b1.cpu_send = 1'b1;
        ld_en = 1'b1; ld_addr = 8'h40; ld_data = 8'h88;
        tick;
        ld_en = 1'b0;
        check("ld_conflict_ack", {15'd0, b1.ram_receive}, 16'd1);
        b1.cpu_send = 1'b0;
        tick;
        b1.mem_ctrl = 2'b00;
        rd(16'h0041, 8'h99);
        rd(16'h0040, 8'h88);
        // RD_LAT=3: abort during RD_WAIT, then a full read
        b3.mem_ctrl = 2'b10; b3.data_addr = 16'h0010; b3.cpu_ready = 1'b1;
        tick;
        b3.cpu_ready = 1'b0;
        tick;
        check("abort_busy", {15'd0, busy3}, 16'd1);
        b3.mem_ctrl = 2'b00;
        tick;
        check("abort_idle", {15'd0, busy3}, 16'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen |= b3.ram_send;
            tick;
        end
        check("abort_no_send", {15'd0, seen}, 16'd0);
        b3.mem_ctrl = 2'b10; b3.cpu_ready = 1'b1;
        tick;
        b3.cpu_ready = 1'b0;
        n = 0;
        while (!b3.ram_send && n < 20) begin
            tick;
            n++;
        end
        check("lat3_latency", 16'(n), 16'd4);
        check("lat3_data", {8'h00, b3.data_read}, 16'h00A5);
        b3.cpu_receive = 1'b1;
        tick;
        check("lat3_release", {14'd0, b3.ram_send, busy3}, 16'd0);
        b3.cpu_receive = 1'b0;
        b3.mem_ctrl = 2'b00;
        // reset while in RD_SEND
        b1.mem_ctrl = 2'b10; b1.data_addr = 16'h0010; b1.cpu_ready = 1'b1;
        tick;
        b1.cpu_ready = 1'b0;
        n = 0;
        while (!b1.ram_send && n < 20) begin
            tick;
            n++;
        end
        check("rst_rdsend_pre", {15'd0, b1.ram_send}, 16'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        b1.mem_ctrl = 2'b00;
        check("rst_rdsend", {3'd0, b1.data_read, b1.ram_send, b1.ram_receive, busy1, err1}, 16'd0);
        // error flag behaviour
        b1.mem_ctrl = 2'b11;
        tick;
        b1.mem_ctrl = 2'b00;
        tick;
        check("err_illegal", {14'd0, busy1, err1}, 16'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("err_cleared", {15'd0, err1}, 16'd0);
        rd(16'h0100, 8'h00);
        check("err_oor_read", {15'd0, err1}, 16'd1);
        wr(16'h0105, 8'h77);
        rd(16'h0005, 8'h34);
        check("err_sticky", {15'd0, err1}, 16'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("err_rst", {15'd0, err1}, 16'd0);
        rd(16'h0020, 8'h3C);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/byte_ram_ctrl.md
Name: byte_ram_ctrl

Overview:
- Byte-wide data/instruction memory slave for the 16-bit multi-cycle CPU.
- Serves the CPU's per-byte handshake:
  - read: mem_ctrl/cpu_ready → ram_send/cpu_receive
  - write: mem_ctrl/cpu_send → ram_receive
- Holds a 2^ADDR_W-byte array with configurable read latency.
- A bench/boot preload port fills the program image before the CPU is enabled.

Parameters:
- ADDR_W, 8: byte-address width; depth = 2^ADDR_W.
- RD_LAT, 1: extra wait cycles between read capture and ram_send (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_ctrl  in  2  2'b10 read, 2'b01 write, 2'b00 idle, 2'b11 illegal.
- data_addr  in  16  CPU byte address.
- data_store  in  8  CPU write byte.
- cpu_ready  in  1  one-cycle read-request pulse.
- cpu_send  in  1  CPU write-valid level.
- cpu_receive  in  1  CPU read-accept level.
- data_read  out  8  read byte to CPU.
- ram_send  out  1  read data valid.
- ram_receive  out  1  write accepted.
- ld_en  in  1  preload write strobe.
- ld_addr  in  ADDR_W  preload address.
- ld_data  in  8  preload byte.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag: illegal mem_ctrl or out-of-range address.

Behaviour:
- All outputs are registered.
- Reset values: data_read=0, ram_send=0, ram_receive=0, busy=0, err=0, state=IDLE, latency counter=0.
- Reset does not clear the memory array.
- Reset mid-transaction returns the block to IDLE on the same edge.
- States: IDLE, RD_WAIT, RD_SEND, WR_ACK.
- IDLE:
  - mem_ctrl==10 && cpu_ready → latch a=data_addr[ADDR_W-1:0], set cnt=RD_LAT, go RD_WAIT.
  - mem_ctrl==01 && cpu_send → mem[a]<=data_store, ram_receive<=1, go WR_ACK.
  - mem_ctrl==11 → err<=1, stay IDLE.
- RD_WAIT:
  - cnt!=0 → cnt--.
  - cnt==0 → data_read<=mem[a], ram_send<=1, go RD_SEND.
  - Latency: cpu_ready sampled at edge k → ram_send high after edge k+1+RD_LAT.
- RD_SEND:
  - Hold ram_send=1 and data_read stable until cpu_receive is sampled 1.
  - On that same edge: ram_send<=0, go IDLE. The CPU sees both signals high on this edge and advances.
  - mem_ctrl!=10 while waiting (abort) → ram_send<=0, go IDLE, no error.
- WR_ACK:
  - Hold ram_receive=1 while cpu_send=1.
  - cpu_send sampled 0 → ram_receive<=0, go IDLE.
  - Re-arm only after cpu_send is seen low, so equal consecutive bytes never double-write or alias the next byte.
- Address range: data_addr[15:ADDR_W]!=0 sets err<=1.
  - Read of such an address returns 8'h00 with normal handshake.
  - Write to such an address is dropped but still acknowledged.
- Preload:
  - ld_en writes mem[ld_addr]<=ld_data in any state.
  - If ld_en and a CPU write hit the same cycle, ld_en wins and the CPU write is dropped but acknowledged.
  - Preload is intended only while the CPU is held disabled.
- cpu_ready while busy is ignored; no queueing.
- Simultaneous read and write request is impossible; mem_ctrl selects exactly one.
- err clears only on rst.
- Byte order: the CPU issues the high byte at the even address and the low byte at address+1 (big-endian); the block itself is byte-agnostic.

Test Plan:
- Preload mem[0x10]=0xA5, RD_LAT=1. mem_ctrl=10, data_addr=0x0010, pulse cpu_ready at edge k → ram_send=1 and data_read=0xA5 after edge k+2. Hold until cpu_receive=1 → ram_send=0 after that edge, busy=0.
- Write handshake: mem_ctrl=01, data_addr=0x0020, data_store=0x3C, cpu_send=1 → ram_receive=1 next cycle; drop cpu_send → ram_receive=0. A subsequent read of 0x20 returns 0x3C.
- Back-to-back equal bytes: write 0x55 to 0x30 then 0x31 with cpu_send low for exactly one cycle between → two acks, mem[0x30]=mem[0x31]=0x55, no extra write to 0x32.
- Abort/reset: start a read with RD_LAT=3, drop mem_ctrl to 00 during RD_WAIT → idle, no ram_send. Repeat with rst asserted in RD_SEND → all outputs 0 next cycle.
- Errors: mem_ctrl=11 → err=1. Read of data_addr=0x0100 (ADDR_W=8) → data_read=0x00, ram_send handshake completes, err=1. Only rst clears err.
- Full CPU integration with the 16-bit CPU (instruction word = big-endian byte pair at even address): preload lw r1,0(r0); sw r1,4(r0) with mem[0]..mem[1] data word 0x1234 → mem[4]=0x12, mem[5]=0x34, and the CPU's done pulse is seen once per instruction.
